inst_sequencer: RTL

Multicycle control sequencer for the RISCAT core. It fetches one instruction at a time over a request/valid instruction-memory handshake and holds it stable for the registered decode stage. It then steps the datapath through decode, execute and writeback, and maintains the PC and a retired-instruction counter. It sits between instruction memory and the decode unit / register file / ALU, and traps on any instruction the current datapath cannot execute.

---
 rtl/inst_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer with halt and trap.
// Ports: imem req/ready/rvalid handshake, decode/ALU/RF strobes, pc, instret, halt/trap status.
module inst_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetched_inst,
  output logic        alu_en,
  output logic        wb_en,
  output logic        retire,
  output logic [31:0] pc,
  output logic [31:0] instret,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_FWAIT  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  logic [2:0]  state_q;
  logic [2:0]  nxt;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [31:0] inst_q;
  logic        trap_q;
  logic [31:0] trap_pc_q;
  logic        legal;

  assign legal = (inst_q[6:0] == 7'b0010011)
              && (inst_q[14:12] != 3'b001)
              && (inst_q[14:12] != 3'b101);

  // req_q keeps imem_req low while in reset and for the
  // first FETCH cycle after it, so nothing is accepted
  // before a request is actually visible.
  always_comb begin
    nxt = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (req_q && imem_ready)
          nxt = S_FWAIT;
        else if (req_q && halt_req)
          nxt = S_HALT;
      end
      S_FWAIT:  if (imem_rvalid) nxt = S_DECODE;
      S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC:   nxt = S_WB;
      S_WB:     nxt = halt_req ? S_HALT : S_FETCH;
      S_HALT:   if (!halt_req) nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      req_q     <= 1'b0;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      inst_q    <= 32'h0000_0013;
      trap_q    <= 1'b0;
      trap_pc_q <= 32'd0;
    end else begin
      state_q <= nxt;
      req_q   <= (nxt == S_FETCH);
      if (state_q == S_FWAIT && imem_rvalid)
        inst_q <= imem_rdata;
      if (state_q == S_DECODE && !legal) begin
        trap_q    <= 1'b1;
        trap_pc_q <= pc_q;
      end
      if (state_q == S_WB) begin
        pc_q      <= pc_q + 32'd4;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign fetched_inst = inst_q;
  assign alu_en       = (state_q == S_EXEC);
  assign wb_en        = (state_q == S_WB);
  assign retire       = (state_q == S_WB);
  assign pc           = pc_q;
  assign instret      = instret_q;
  assign halted       = (state_q == S_HALT)
                     || (state_q == S_TRAP);
  assign trap         = trap_q;
  assign trap_pc      = trap_pc_q;

endmodule
